// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the five-stage pipeline.
// It owns the architectural HI/LO registers. The result is computed when an
// operation is accepted. A down-counter then models the multi-cycle latency
// before HI/LO are committed.
//
// Ports:
//   clk      pipeline clock, rising edge
//   reset    asynchronous active-low reset
//   start    E-stage instruction is an MDU op (qualifies op)
//   op       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a    forwarded rs value
//   src_b    forwarded rt value
//   use_md   E-stage instruction reads or writes HI/LO
//   busy     operation in flight
//   stall_md use_md && busy, combinational, to the hazard unit
//   hi, lo   architectural HI/LO
//
// Build option: define MDU_DIV_EN to include the divider. When it is
// undefined, DIV/DIVU behave as no-ops.

module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        use_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
`endif
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Latency to load: op[1] separates divide from multiply.
    logic [3:0]  load_cnt;
    assign load_cnt = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

    // One 64-bit multiplier: zero- or sign-extend the operands by op[0].
    // The low 64 bits of the product are then correct for both forms.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    always_comb begin
        ext_a = {(op[0] ? 32'd0 : {32{src_a[31]}}), src_a};
        ext_b = {(op[0] ? 32'd0 : {32{src_b[31]}}), src_b};
        prod  = ext_a * ext_b;
    end

`ifdef MDU_DIV_EN
    // One unsigned divider on operand magnitudes. Signs are restored after.
    // The quotient truncates toward zero. The remainder follows the dividend.
    // 0x80000000 / -1 wraps back to 0x80000000 with a zero remainder.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] den;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    always_comb begin
        a_neg  = ~op[0] & src_a[31];
        b_neg  = ~op[0] & src_b[31];
        mag_a  = a_neg ? (~src_a + 32'd1) : src_a;
        mag_b  = b_neg ? (~src_b + 32'd1) : src_b;
        den    = (src_b == 32'd0) ? 32'd1 : mag_b;
        uq     = mag_a / den;
        ur     = mag_a % den;
        div_lo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        div_hi = a_neg ? (~ur + 32'd1) : ur;
        if (src_b == 32'd0) begin
            div_hi = src_a;
            div_lo = 32'hFFFF_FFFF;
        end
    end
`endif

    // Sequencer and HI/LO ownership.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                res_hi <= prod[63:32];
                                res_lo <= prod[31:0];
                                cnt    <= load_cnt;
                                state  <= RUN;
                            end
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                res_hi <= div_hi;
                                res_lo <= div_lo;
                                cnt    <= load_cnt;
                                state  <= RUN;
                            end
`endif
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // A start pulse here is ignored; the hazard unit holds the op.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign stall_md = use_md & busy;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl. It uses directed vectors with literal expectations.
// A behavioural HI/LO model is compared against the DUT on every cycle.
module tb_mdu_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        use_md = 1'b0;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .use_md(use_md),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    bit          m_busy = 0;
    int          cyc = 0, commit_at = 0;

    task automatic model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        int          q, r;
        rh = 0; rl = 0;
        case (o)
            3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin
                if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rh = 0; rl = 32'h8000_0000; end
                else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); rh = 32'(r); rl = 32'(q); end
            end
            3'd3: begin
                if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else begin rh = a % b; rl = a / b; end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_busy = 0; cyc = 0; commit_at = 0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc == commit_at) begin m_hi = p_hi; m_lo = p_lo; m_busy = 0; end
            end else if (start) begin
                if (op <= 3'd1) begin
                    model_result(op, src_a, src_b, p_hi, p_lo);
                    commit_at = cyc + MC; m_busy = 1;
                end
`ifdef MDU_DIV_EN
                else if (op <= 3'd3) begin
                    model_result(op, src_a, src_b, p_hi, p_lo);
                    commit_at = cyc + DC; m_busy = 1;
                end
`endif
                else if (op == 3'd4) m_hi = src_a;
                else if (op == 3'd5) m_lo = src_a;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("stall_md", 32'(stall_md), 32'(use_md && m_busy));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    // ---------------- stimulus ----------------
    // Entered away from edges; returns at posedge+1 after the accepting edge.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 0; op = 3'd7; src_a = $urandom; src_b = $urandom;
    endtask

    // Counts busy cycles; returns at negedge+1 of the first not-busy cycle.
    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 40) begin
                tests++; fails++;
                $display("FAIL wait_done: busy stuck, got %0d cycles expected <= 40", n);
                break;
            end
        end
        #1;
    endtask

    int n;

    initial begin
        #30;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;

        // MULT -2 * 3
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        chk("mult_busy_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU same operands
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        chk("multu_busy_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
`ifdef MDU_DIV_EN
        chk("div_busy_cycles", 32'(n), 32'd10);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);
`else
        chk("div_busy_cycles", 32'(n), 32'd0);
        chk("div_hi", hi, 32'h0000_0002);
        chk("div_lo", lo, 32'hFFFF_FFFA);
`endif

        // DIVU 7 / 0
        do_op(3'd3, 32'd7, 32'd0);
        wait_done(n);
`ifdef MDU_DIV_EN
        chk("divu0_hi", hi, 32'd7);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        // Signed overflow
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h8000_0000);
        // DIVU 100 / 7
        do_op(3'd3, 32'd100, 32'd7);
        wait_done(n);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);
`else
        chk("divu0_busy_cycles", 32'(n), 32'd0);
`endif

        // MULT then MFLO next cycle; a start pulse during the run is ignored.
        do_op(3'd0, 32'd6, 32'd7);
        use_md = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall_md) break;
            n++;
            if (n == 2) begin
                #1; start = 1; op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
                @(posedge clk); #1; start = 0; op = 3'd7;
            end
        end
        chk("mflo_stall_cycles", 32'(n), 32'd5);
        chk("mflo_release_stall", 32'(stall_md), 32'd0);
        chk("mult_run_lo", lo, 32'd42);
        chk("mult_run_hi", hi, 32'd0);
        #1; use_md = 0;

        // MTHI in the first non-busy cycle after a run.
        do_op(3'd0, 32'h0001_0000, 32'h0001_0000);
        wait_done(n);
        chk("mult_big_hi", hi, 32'd1);
        do_op(3'd4, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        chk("mthi_after_run", hi, 32'hCAFE_F00D);
        chk("mthi_keeps_lo", lo, 32'd0);
        #1;

        // Reset in the 3rd busy cycle aborts the operation.
`ifdef MDU_DIV_EN
        do_op(3'd2, 32'd50, 32'd3);
`else
        do_op(3'd0, 32'd50, 32'd3);
`endif
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk); #1; reset = 1;
        @(posedge clk); #1;
        do_op(3'd5, 32'h0000_1234, 32'd0);
        @(negedge clk);
        chk("mtlo_after_reset", lo, 32'h0000_1234);
        chk("mtlo_not_busy", 32'(busy), 32'd0);
        #1;

        // Ops 6/7 are no-ops.
        do_op(3'd6, 32'h1111_1111, 32'd0);
        wait_done(n);
        chk("noop_busy_cycles", 32'(n), 32'd0);
        chk("noop_lo", lo, 32'h0000_1234);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
